maxnet_seq: RTL
===============

MAXNET_SEQ -- requirements
Module: maxnet_seq

Interface
REQ-001 Parameter MAX_ITER, default 15: iteration limit, legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  load request, accepted only when in_ready=1.
REQ-005 in_ready  out  1  high only in IDLE.
REQ-006 a0..a3  in  5 each  initial activations, signed two's complement, 3 fraction bits (01000 = 1.0).
REQ-007 act0..act3  out  5 each  registered activations driven to the four processing units.
REQ-008 pu_en  out  1  product-register enable to the processing units.
REQ-009 new0..new3  in  5 each  updated activations returned by the processing units.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  result accepted.
REQ-012 winner  out  2  index of the sole surviving nonzero activation.
REQ-013 none  out  1  all activations reached zero; no winner.
REQ-014 timeout  out  1  MAX_ITER reached without convergence.

Function
REQ-015 FSM states: IDLE, FEED, UPD, CHECK, DONE.
REQ-016 IDLE: when start=1, capture a0..a3 into act0..act3, clear iter, and go to FEED; start is ignored in every other state.
REQ-017 Load clamp: a negative input (bit 4 = 1) is loaded as 00000.
REQ-018 FEED: pu_en=1 for exactly one cycle, then go to UPD; pu_en=0 in all other states.
REQ-019 UPD: act_i <= new_i for all i simultaneously, iter <= iter+1, then go to CHECK.
REQ-020 CHECK, count of nonzero act is 1: go to DONE with winner = that index, none=0, timeout=0.
REQ-021 CHECK, count is 0: go to DONE with none=1 and winner=0.
REQ-022 CHECK, count is at least 2 and iter=MAX_ITER: go to DONE with timeout=1 and winner=0.
REQ-023 CHECK, otherwise: go to FEED.
REQ-024 Convergence is tested only in CHECK; no early test is made at load, so the minimum iteration count is 1.
REQ-025 Each iteration takes 3 cycles; a result is available after at most 1 + 3*MAX_ITER cycles from start.
REQ-026 DONE: out_valid=1, with winner, none and timeout held stable until out_ready=1; then clear out_valid and go to IDLE in the same edge.
REQ-027 No output changes while out_valid=1 and out_ready=0.
REQ-028 iter is 8 bits and never wraps, because CHECK bounds it at MAX_ITER.
REQ-029 act0..act3 retain their final values through DONE and IDLE until the next load.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, act0..act3=0, iter=0, pu_en=0, out_valid=0, winner=0, none=0, timeout=0.
REQ-031 Reset asserted in any state aborts the run; no partial result is ever presented.

Configuration
REQ-032 With MAXNET_ITER_OUT_EN defined, an extra 8-bit output iter_cnt presents the iteration count, valid while out_valid=1.
REQ-033 Without MAXNET_ITER_OUT_EN, the port and its logic are absent and function is otherwise identical.

Structure
REQ-034 Shared package holds: the state enum, the activation width (5), the fraction-bit count (3), the neuron count (4), and the constant ZERO_ACT.
REQ-035 One sub-module, nz_count, produces the nonzero count and the single-hot index from act0..act3.
REQ-036 Per-unit input rotation (own activation first) is done in the enclosing top-level wiring, not in this block.

Verification (the bench uses a behavioural model of the processing unit: self weight 1.0, others -0.25, truncation, ReLU)
REQ-037 a=(00000,00000,01000,00000) -> out_valid after 1 iteration, winner=2, none=0, timeout=0.
REQ-038 a=(11000,00010,00000,00000) -> a0 clamped to 0; winner=1 after 1 iteration.
REQ-039 a=(00100,00100,00100,00100) -> equal values decay together; none=1, timeout=0, within MAX_ITER.
REQ-040 MAX_ITER=1, a=(01000,00100,00000,00000) -> timeout=1, act0=00111, act1=00010.
REQ-041 Hold out_ready=0 for 5 cycles in DONE -> outputs are stable and no second start is accepted; release out_ready -> IDLE, in_ready=1.
REQ-042 Assert rst=0 during FEED of iteration 2 -> all outputs at reset values within the same cycle; a fresh start then completes correctly.

Source files
------------

// File: rtl/maxnet_seq_pkg.sv
// Shared types and constants for the MAXNET winner-take-all sequencer.
package maxnet_seq_pkg;

  localparam int unsigned ACT_W    = 5;
  localparam int unsigned FRAC_W   = 3;
  localparam int unsigned N_NEURON = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned ITER_W   = 8;

  typedef logic [ACT_W-1:0] act_t;

  localparam act_t ZERO_ACT = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_UPD,
    S_CHECK,
    S_DONE
  } state_t;

  // Negative initial activations are meaningless for MAXNET; load them as zero.
  function automatic act_t clamp_load(act_t a);
    return a[ACT_W-1] ? ZERO_ACT : a;
  endfunction

endpackage

// File: rtl/maxnet_seq_if.sv
// Load / processing-unit / result bundle for maxnet_seq.
// Adds iter_cnt when MAXNET_ITER_OUT_EN is defined.
interface maxnet_seq_if;
  import maxnet_seq_pkg::*;

  logic             start;
  logic             in_ready;
  act_t             a0, a1, a2, a3;
  act_t             act0, act1, act2, act3;
  logic             pu_en;
  act_t             new0, new1, new2, new3;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] winner;
  logic             none;
  logic             timeout;
`ifdef MAXNET_ITER_OUT_EN
  logic [ITER_W-1:0] iter_cnt;
`endif

  // Sequencer side.
  modport slave (
    input  start, a0, a1, a2, a3, new0, new1, new2, new3, out_ready,
    output in_ready, act0, act1, act2, act3, pu_en, out_valid, winner, none, timeout
`ifdef MAXNET_ITER_OUT_EN
    , output iter_cnt
`endif
  );

  // Environment side (loader, processing units, result consumer).
  modport master (
    output start, a0, a1, a2, a3, new0, new1, new2, new3, out_ready,
    input  in_ready, act0, act1, act2, act3, pu_en, out_valid, winner, none, timeout
`ifdef MAXNET_ITER_OUT_EN
    , input iter_cnt
`endif
  );

endinterface

// File: rtl/maxnet_seq_nz_count.sv
// Counts nonzero activations and reports the index of the last nonzero one
// (the sole survivor when the count is one).
module maxnet_seq_nz_count
  import maxnet_seq_pkg::*;
(
  input  act_t             act [N_NEURON],
  output logic [CNT_W-1:0] cnt_c,
  output logic [IDX_W-1:0] idx_c
);

  // Population count of nonzero activations plus a survivor index.
  always_comb begin
    cnt_c = '0;
    idx_c = '0;
    for (int unsigned i = 0; i < N_NEURON; i++) begin
      if (act[i] != ZERO_ACT) begin
        cnt_c = cnt_c + CNT_W'(1);
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/maxnet_seq.sv
// MAXNET iteration sequencer: loads activations, steps the external
// processing units until one survivor, none, or MAX_ITER, then presents
// the result with a valid/ready handshake.
// Optional: MAXNET_ITER_OUT_EN exports the iteration count as iter_cnt.
module maxnet_seq
  import maxnet_seq_pkg::*;
#(
  parameter int unsigned MAX_ITER = 15
) (
  input logic         clk,
  input logic         rst,
  maxnet_seq_if.slave bus
);

  state_t            state_q, state_d;
  act_t              act_q [N_NEURON];
  act_t              act_d [N_NEURON];
  act_t              ld    [N_NEURON];
  act_t              upd   [N_NEURON];
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              in_ready_q, in_ready_d;
  logic              pu_en_q, pu_en_d;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic              none_q, none_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  nz_cnt;
  logic [IDX_W-1:0]  nz_idx;

  assign ld  = '{bus.a0, bus.a1, bus.a2, bus.a3};
  assign upd = '{bus.new0, bus.new1, bus.new2, bus.new3};

  maxnet_seq_nz_count u_nz_count (
    .act   (act_q),
    .cnt_c (nz_cnt),
    .idx_c (nz_idx)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    iter_d      = iter_q;
    in_ready_d  = in_ready_q;
    pu_en_d     = 1'b0;
    out_valid_d = out_valid_q;
    winner_d    = winner_q;
    none_d      = none_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < N_NEURON; i++) begin
            act_d[i] = clamp_load(ld[i]);
          end
          iter_d     = '0;
          in_ready_d = 1'b0;
          pu_en_d    = 1'b1;
          state_d    = S_FEED;
        end
      end
      S_FEED: begin
        state_d = S_UPD;
      end
      S_UPD: begin
        act_d   = upd;
        iter_d  = iter_q + ITER_W'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (nz_cnt == CNT_W'(1)) begin
          winner_d    = nz_idx;
          none_d      = 1'b0;
          timeout_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (nz_cnt == CNT_W'(0)) begin
          winner_d    = '0;
          none_d      = 1'b1;
          timeout_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          winner_d    = '0;
          none_d      = 1'b0;
          timeout_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          pu_en_d = 1'b1;
          state_d = S_FEED;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      act_q       <= '{default: ZERO_ACT};
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      pu_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      winner_q    <= '0;
      none_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      iter_q      <= iter_d;
      in_ready_q  <= in_ready_d;
      pu_en_q     <= pu_en_d;
      out_valid_q <= out_valid_d;
      winner_q    <= winner_d;
      none_q      <= none_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.pu_en     = pu_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.winner    = winner_q;
  assign bus.none      = none_q;
  assign bus.timeout   = timeout_q;
  assign bus.act0      = act_q[0];
  assign bus.act1      = act_q[1];
  assign bus.act2      = act_q[2];
  assign bus.act3      = act_q[3];
`ifdef MAXNET_ITER_OUT_EN
  assign bus.iter_cnt  = iter_q;
`endif

endmodule
